// File: rtl/sseg_capture.sv
// sseg_capture
// Watches a multiplexed seven-segment bus and recovers the hex nibble shown
// on each digit. A strobe/segment pattern must stay unchanged for
// STABLE_CYCLES consecutive samples before it is committed. This rejects
// scan glitches and commits each stable run exactly once.
//
// Ports:
//   clk      system clock; all state updates on the rising edge
//   rst      synchronous active-high reset
//   seg_in   segment lines, bit0=a .. bit6=g, bit7=decimal point
//   dig_sel  one-hot digit strobes
//   hex_out  recovered nibble per digit; digit i at [4i+3:4i]
//   dp_out   decimal-point state per digit
//   valid    digit holds a decoded hex value
//   blank    digit last committed with all seven segments off
//   update   one-cycle pulse on a successful commit (hex or blank)
//   pat_err  one-cycle pulse when a stable pattern is not a hex glyph
//   sel_err  one-cycle pulse when a stable strobe has more than one bit set
module sseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    update,
    output logic                    pat_err,
    output logic                    sel_err
);

    localparam int         SW        = NUM_DIGITS + 8;
    localparam logic [3:0] STABLE_C  = 4'(STABLE_CYCLES);
    localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);

    // Segment pattern to {recognised, nibble}.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0111111: r = {1'b1, 4'h0};
            7'b0000110: r = {1'b1, 4'h1};
            7'b1011011: r = {1'b1, 4'h2};
            7'b1001111: r = {1'b1, 4'h3};
            7'b1100110: r = {1'b1, 4'h4};
            7'b1101101: r = {1'b1, 4'h5};
            7'b1111101: r = {1'b1, 4'h6};
            7'b0000111: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1100111: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b1111100: r = {1'b1, 4'hB};
            7'b0111001: r = {1'b1, 4'hC};
            7'b1011110: r = {1'b1, 4'hD};
            7'b1111001: r = {1'b1, 4'hE};
            7'b1110001: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic multi_hot(input logic [NUM_DIGITS-1:0] v);
        return (v & (v - NUM_DIGITS'(1))) != '0;
    endfunction

    logic [SW-1:0] samp_r;
    logic [SW-1:0] prev_r;
    logic [3:0]    cnt_r;

    logic [3:0]    cnt_next_s;
    logic          commit_s;
    logic          changed_s;
    logic          strobe_zero_s;
    logic          multi_s;
    logic          code_ok_s;
    logic [3:0]    code_s;
    logic          blank_pat_s;

    // Stability counting and commit detection on the registered sample.
    always_comb begin
        cnt_next_s    = cnt_r;
        commit_s      = 1'b0;
        changed_s     = (samp_r != prev_r);
        strobe_zero_s = (samp_r[SW-1:8] == '0);
        multi_s       = multi_hot(samp_r[SW-1:8]);
        {code_ok_s, code_s} = seg_decode(samp_r[6:0]);
        blank_pat_s   = (samp_r[6:0] == 7'b0000000);

        if (strobe_zero_s) begin
            cnt_next_s = 4'd0;
            commit_s   = 1'b0;
        end else if (changed_s) begin
            // A new value is its own first sample; with a threshold of one it commits right away.
            cnt_next_s = 4'd1;
            commit_s   = (STABLE_CYCLES == 1);
        end else if (cnt_r == STABLE_C) begin
            // Saturated: this run has already committed.
            cnt_next_s = cnt_r;
            commit_s   = 1'b0;
        end else begin
            cnt_next_s = cnt_r + 4'd1;
            commit_s   = (cnt_r == STABLE_M1);
        end
    end

    // Sample pipeline, counter, per-digit registers and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_r  <= '0;
            prev_r  <= '0;
            cnt_r   <= 4'd0;
            hex_out <= '0;
            dp_out  <= '0;
            valid   <= '0;
            blank   <= '0;
            update  <= 1'b0;
            pat_err <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            samp_r  <= {dig_sel, seg_in};
            prev_r  <= samp_r;
            cnt_r   <= cnt_next_s;
            update  <= 1'b0;
            pat_err <= 1'b0;
            sel_err <= 1'b0;
            if (commit_s) begin
                if (multi_s) begin
                    sel_err <= 1'b1;
                end else if (code_ok_s || blank_pat_s) begin
                    update <= 1'b1;
                    // Strobe is one-hot here, so only the selected digit is touched.
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (samp_r[8+i]) begin
                            dp_out[i] <= samp_r[7];
                            valid[i]  <= code_ok_s;
                            blank[i]  <= blank_pat_s;
                            if (code_ok_s) begin
                                hex_out[4*i +: 4] <= code_s;
                            end
                        end
                    end
                end else begin
                    pat_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_capture.sv
// Self-checking bench for sseg_capture: directed scenarios plus random bus
// traffic, predicted by a run-length reference model feeding a scoreboard
// queue that a negedge monitor drains.
module tb_sseg_capture;

    localparam int ND     = 4;
    localparam int STABLE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    seg_in;
    logic [ND-1:0] dig_sel;
    logic [15:0]   hex_out;
    logic [3:0]    dp_out, valid, blank;
    logic          update, pat_err, sel_err;

    sseg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
        .hex_out(hex_out), .dp_out(dp_out), .valid(valid), .blank(blank),
        .update(update), .pat_err(pat_err), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  pulses;   // {update, pat_err, sel_err}
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  vld;
        logic [3:0]  blk;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    logic [2:0] mon_p;

    int checks = 0;
    int errors = 0;

    logic [6:0]  tbl [16];
    logic [15:0] m_hex;
    logic [3:0]  m_dp, m_vld, m_blk;
    logic [11:0] prev_v, pend_v;
    int          run;
    bit          pending;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Commit effect of a stable sample, from the behavioural description.
    task automatic apply(input logic [11:0] v);
        logic [3:0] d;
        logic [7:0] s;
        exp_t x;
        int idx, code;
        bit found;
        d = v[11:8];
        s = v[7:0];
        idx = 0; code = 0; found = 0;
        if ($countones(d) > 1) begin
            x.pulses = 3'b001;
        end else begin
            for (int i = 0; i < ND; i++) if (d[i]) idx = i;
            for (int n = 0; n < 16; n++) if (tbl[n] == s[6:0]) begin found = 1; code = n; end
            if (found) begin
                m_hex[4*idx +: 4] = code[3:0];
                m_vld[idx] = 1'b1; m_blk[idx] = 1'b0; m_dp[idx] = s[7];
                x.pulses = 3'b100;
            end else if (s[6:0] == 7'd0) begin
                m_vld[idx] = 1'b0; m_blk[idx] = 1'b1; m_dp[idx] = s[7];
                x.pulses = 3'b100;
            end else begin
                x.pulses = 3'b010;
            end
        end
        x.hex = m_hex; x.dp = m_dp; x.vld = m_vld; x.blk = m_blk;
        exp_q.push_back(x);
    endtask

    // Reference model step for one rising edge. run counts identical
    // consecutive samples, capped at STABLE+1 once a run has committed.
    task automatic model_edge(input logic r, input logic [3:0] d, input logic [7:0] s);
        logic [11:0] v;
        v = {d, s};
        if (r) begin
            pending = 0; run = 0; prev_v = '0;
            m_hex = '0; m_dp = '0; m_vld = '0; m_blk = '0;
        end else begin
            if (pending) begin
                apply(pend_v);
                pending = 0;
            end
            if (d == 4'd0) run = 0;
            else if (v != prev_v) run = 1;
            else if (run <= STABLE) run = run + 1;
            if (d != 4'd0 && run == STABLE) begin
                pending = 1;
                pend_v = v;
            end
            prev_v = v;
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] d, input logic [7:0] s);
        rst = r; dig_sel = d; seg_in = s;
        @(posedge clk);
        model_edge(r, d, s);
        #1;
    endtask

    task automatic hold(input int n, input logic [3:0] d, input logic [7:0] s);
        for (int i = 0; i < n; i++) cycle(1'b0, d, s);
    endtask

    // Scoreboard monitor: every edge either produces the queued event or no pulse.
    always @(negedge clk) begin
        mon_p = {update, pat_err, sel_err};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (mon_p !== e.pulses || hex_out !== e.hex || dp_out !== e.dp ||
                valid !== e.vld || blank !== e.blk) begin
                errors++;
                $display("FAIL commit_event: got pulses=%b hex=%h dp=%b valid=%b blank=%b, expected pulses=%b hex=%h dp=%b valid=%b blank=%b",
                         mon_p, hex_out, dp_out, valid, blank, e.pulses, e.hex, e.dp, e.vld, e.blk);
            end
        end else if (mon_p !== 3'b000) begin
            checks++;
            errors++;
            $display("FAIL spurious_pulse: got pulses=%b expected 000", mon_p);
        end
    end

    initial begin
        tbl[0]  = 7'b0111111; tbl[1]  = 7'b0000110; tbl[2]  = 7'b1011011; tbl[3]  = 7'b1001111;
        tbl[4]  = 7'b1100110; tbl[5]  = 7'b1101101; tbl[6]  = 7'b1111101; tbl[7]  = 7'b0000111;
        tbl[8]  = 7'b1111111; tbl[9]  = 7'b1100111; tbl[10] = 7'b1110111; tbl[11] = 7'b1111100;
        tbl[12] = 7'b0111001; tbl[13] = 7'b1011110; tbl[14] = 7'b1111001; tbl[15] = 7'b1110001;
        m_hex = '0; m_dp = '0; m_vld = '0; m_blk = '0;
        prev_v = '0; pend_v = '0; run = 0; pending = 0;

        // Reset with bus activity
        cycle(1'b1, 4'($urandom), 8'($urandom));
        cycle(1'b1, 4'($urandom), 8'($urandom));
        chk("reset_hex", 32'(hex_out), 32'h0);
        chk("reset_dp", 32'(dp_out), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_blank", 32'({update, pat_err, sel_err, blank}), 32'h0);
        hold(3, 4'd0, 8'h00);

        // Basic decode
        hold(5, 4'b0100, 8'h5B);
        chk("basic_hex", 32'(hex_out[11:8]), 32'h2);
        chk("basic_valid", 32'(valid), 32'h4);
        chk("basic_dp", 32'(dp_out[2]), 32'h0);

        // Full scan
        hold(4, 4'b0001, 8'h07);
        hold(4, 4'b0010, 8'hFF);
        hold(4, 4'b0100, 8'h77);
        hold(4, 4'b1000, 8'h71);
        chk("scan_hex", 32'(hex_out), 32'hFA87);
        chk("scan_dp", 32'(dp_out), 32'h2);
        chk("scan_valid", 32'(valid), 32'hF);

        // Glitch rejection
        hold(2, 4'b0001, 8'h06);
        hold(3, 4'b0001, 8'h4F);
        hold(1, 4'b0000, 8'h00);
        chk("glitch_hex", 32'(hex_out[3:0]), 32'h3);

        // Errors
        hold(3, 4'b0010, 8'h49);
        hold(1, 4'b0000, 8'h00);
        chk("paterr_keep", 32'(hex_out[7:4]), 32'h8);
        hold(3, 4'b0011, 8'h06);
        hold(1, 4'b0000, 8'h00);
        chk("selerr_keep", 32'(hex_out), 32'hFA83);

        // Blank
        hold(4, 4'b1000, 8'h3F);
        hold(4, 4'b1000, 8'h00);
        chk("blank_bit", 32'(blank[3]), 32'h1);
        chk("blank_valid", 32'(valid[3]), 32'h0);
        chk("blank_hex", 32'(hex_out[15:12]), 32'h0);

        // Reset mid-run
        hold(2, 4'b0001, 8'h06);
        cycle(1'b1, 4'b0001, 8'h06);
        hold(3, 4'b0000, 8'h00);
        chk("midrst_out", 32'({hex_out, dp_out, valid, blank}), 32'h0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [3:0] d;
            logic [7:0] s;
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)       s = {1'($urandom_range(0, 1)), tbl[$urandom_range(0, 15)]};
            else if (r == 6) s = {1'($urandom_range(0, 1)), 7'd0};
            else             s = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r < 8)       d = 4'b0001 << $urandom_range(0, 3);
            else if (r == 8) d = 4'd0;
            else             d = 4'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                for (int j = 0; j < $urandom_range(1, 2); j++) cycle(1'b1, d, s);
            end
            hold($urandom_range(1, 5), d, s);
        end
        hold(STABLE + 2, 4'd0, 8'h00);

        chk("final_hex", 32'(hex_out), 32'(m_hex));
        chk("final_flags", 32'({dp_out, valid, blank}), 32'({m_dp, m_vld, m_blk}));
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
